// File: rtl/cam_awb_ctrl.sv
`default_nettype none
// =============================================================================
// cam_awb_ctrl : per-frame Bayer R/G/B accumulation and one-code-per-frame
//                red/blue gain stepping toward grey balance (4PPC stream)
// Revision     : 1.0
// =============================================================================
module cam_awb_ctrl #(
  parameter int P_DEPTH     = 10,
  parameter int PW          = P_DEPTH*4,
  parameter int FRAME_WIDTH = 640,
  parameter int ACC_W       = 28,
  parameter int DB_SHIFT    = 4
) (
  input  logic          i_pclk,
  input  logic          i_arstn,
  input  logic          i_vs,
  input  logic          i_valid,
  input  logic [PW-1:0] i_data,
  input  logic          i_awb_en,
  input  logic [2:0]    i_man_red_gain,
  input  logic [2:0]    i_man_blue_gain,
  input  logic [2:0]    i_green_gain,
  output logic [2:0]    o_red_gain,
  output logic [2:0]    o_green_gain,
  output logic [2:0]    o_blue_gain,
  output logic          o_frame_done,
  output logic          o_locked
);

  localparam int              BEATS   = FRAME_WIDTH/4;
  localparam int              CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BEATS-1);
  localparam logic [2:0]      C_UNITY = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_CALC   = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               vs_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               par_q, par_d;
  logic [ACC_W-1:0]   acc_r_q, acc_g_q, acc_b_q;
  logic [ACC_W-1:0]   acc_r_d, acc_g_d, acc_b_d;
  logic [ACC_W-1:0]   snap_r_q, snap_g_q, snap_b_q;
  logic [ACC_W-1:0]   lo_q, hi_q;
  logic [2:0]         red_q, red_d, blue_q, blue_d, green_q;
  logic               done_q, done_d, locked_q, locked_d;

  logic               w_vs_fall;
  logic               w_par_eff;
  logic [CNT_W-1:0]   w_cnt_base;
  logic [P_DEPTH-1:0] w_pix0, w_pix1, w_pix2, w_pix3;
  logic [P_DEPTH:0]   w_pair_hi, w_pair_lo;
  logic [ACC_W-1:0]   w_base_r, w_base_g, w_base_b;
  logic [ACC_W-1:0]   w_gn, w_db;
  logic               w_r_in, w_b_in;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                input logic [P_DEPTH:0]   b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W-P_DEPTH){1'b0}}, b};
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  function automatic logic [2:0] step_code(input logic [2:0]       code,
                                           input logic [ACC_W-1:0] x,
                                           input logic [ACC_W-1:0] lo,
                                           input logic [ACC_W-1:0] hi);
    logic [2:0] c;
    c = code;
    if (x < lo && code != 3'd7)
      c = code + 3'd1;
    else if (x > hi && code != 3'd0)
      c = code - 3'd1;
    return c;
  endfunction

  assign w_vs_fall = vs_q & ~i_vs;
  assign w_pix0    = i_data[0*P_DEPTH +: P_DEPTH];
  assign w_pix1    = i_data[1*P_DEPTH +: P_DEPTH];
  assign w_pix2    = i_data[2*P_DEPTH +: P_DEPTH];
  assign w_pix3    = i_data[3*P_DEPTH +: P_DEPTH];
  assign w_pair_hi = {1'b0, w_pix3} + {1'b0, w_pix1};
  assign w_pair_lo = {1'b0, w_pix2} + {1'b0, w_pix0};

  // A beat coincident with the vs fall belongs to the new frame (line 0, parity 0).
  assign w_cnt_base = w_vs_fall ? '0 : cnt_q;
  assign w_par_eff  = w_vs_fall ? 1'b0 : par_q;

  always_comb begin
    cnt_d = w_cnt_base;
    par_d = w_par_eff;
    if (i_valid) begin
      if (w_cnt_base == C_LAST) begin
        cnt_d = '0;
        par_d = ~w_par_eff;
      end else begin
        cnt_d = w_cnt_base + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_base_r = acc_r_q;
    w_base_g = acc_g_q;
    w_base_b = acc_b_q;
    if (state_q == S_ACCUM && w_vs_fall) begin
      w_base_r = '0;
      w_base_g = '0;
      w_base_b = '0;
    end
    acc_r_d = w_base_r;
    acc_g_d = w_base_g;
    acc_b_d = w_base_b;
    if (state_q == S_IDLE) begin
      acc_r_d = '0;
      acc_g_d = '0;
      acc_b_d = '0;
    end else if (i_valid) begin
      if (!w_par_eff) begin
        acc_r_d = sat_add(w_base_r, w_pair_lo);
        acc_g_d = sat_add(w_base_g, w_pair_hi);
      end else begin
        acc_b_d = sat_add(w_base_b, w_pair_hi);
        acc_g_d = sat_add(w_base_g, w_pair_lo);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (w_vs_fall) state_d = S_ACCUM;
      S_ACCUM:  if (w_vs_fall) state_d = S_CALC;
      S_CALC:   state_d = S_UPDATE;
      S_UPDATE: state_d = S_ACCUM;
      default:  state_d = S_IDLE;
    endcase
  end

  // G sum covers twice as many pixels as R or B, so halve it before comparing.
  assign w_gn   = snap_g_q >> 1;
  assign w_db   = w_gn >> DB_SHIFT;
  assign w_r_in = (snap_r_q >= lo_q) && (snap_r_q <= hi_q);
  assign w_b_in = (snap_b_q >= lo_q) && (snap_b_q <= hi_q);

  always_comb begin
    red_d    = red_q;
    blue_d   = blue_q;
    done_d   = 1'b0;
    locked_d = locked_q;
    if (!i_awb_en) begin
      red_d    = i_man_red_gain;
      blue_d   = i_man_blue_gain;
      locked_d = 1'b0;
    end
    if (state_q == S_UPDATE) begin
      done_d = 1'b1;
      if (i_awb_en) begin
        red_d    = step_code(red_q,  snap_r_q, lo_q, hi_q);
        blue_d   = step_code(blue_q, snap_b_q, lo_q, hi_q);
        locked_d = w_r_in & w_b_in;
      end
    end
  end

  always_ff @(posedge i_pclk) begin
    if (!i_arstn) begin
      state_q  <= S_IDLE;
      vs_q     <= 1'b0;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      acc_r_q  <= '0;
      acc_g_q  <= '0;
      acc_b_q  <= '0;
      snap_r_q <= '0;
      snap_g_q <= '0;
      snap_b_q <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      red_q    <= C_UNITY;
      blue_q   <= C_UNITY;
      green_q  <= C_UNITY;
      done_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vs_q     <= i_vs;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      acc_r_q  <= acc_r_d;
      acc_g_q  <= acc_g_d;
      acc_b_q  <= acc_b_d;
      if (state_q == S_ACCUM && w_vs_fall) begin
        snap_r_q <= acc_r_q;
        snap_g_q <= acc_g_q;
        snap_b_q <= acc_b_q;
      end
      if (state_q == S_CALC) begin
        lo_q <= w_gn - w_db;
        hi_q <= w_gn + w_db;
      end
      red_q    <= red_d;
      blue_q   <= blue_d;
      green_q  <= i_green_gain;
      done_q   <= done_d;
      locked_q <= locked_d;
    end
  end

  assign o_red_gain   = red_q;
  assign o_green_gain = green_q;
  assign o_blue_gain  = blue_q;
  assign o_frame_done = done_q;
  assign o_locked     = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_awb_ctrl.sv
`default_nettype none
// =============================================================================
// tb_cam_awb_ctrl : scoreboard bench; frame-level reference model of the AWB
// Revision        : 1.0
// =============================================================================
module tb_cam_awb_ctrl;

  localparam int P     = 10;
  localparam int PW    = P*4;
  localparam int FW    = 640;
  localparam int BEATS = FW/4;

  logic          clk = 1'b0;
  logic          arstn, vs, valid, en;
  logic [PW-1:0] data;
  logic [2:0]    man_r, man_b, green;
  logic [2:0]    o_red, o_green, o_blue;
  logic          o_done, o_locked;

  always #5 clk = ~clk;

  cam_awb_ctrl #(.P_DEPTH(P), .PW(PW), .FRAME_WIDTH(FW), .ACC_W(28), .DB_SHIFT(4)) dut (
    .i_pclk(clk), .i_arstn(arstn), .i_vs(vs), .i_valid(valid), .i_data(data),
    .i_awb_en(en), .i_man_red_gain(man_r), .i_man_blue_gain(man_b),
    .i_green_gain(green), .o_red_gain(o_red), .o_green_gain(o_green),
    .o_blue_gain(o_blue), .o_frame_done(o_done), .o_locked(o_locked)
  );

  typedef struct {
    int         cyc;
    logic [2:0] r;
    logic [2:0] b;
    bit         lk;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;

  // Reference model state: colour sums of the frame in flight (0=R 1=G 2=B).
  longint     sum[3];
  int         base[3];
  logic [2:0] m_r, m_b;
  bit         m_en, primed;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] mstep(input logic [2:0] c, input longint x,
                                       input longint lo, input longint hi);
    if (x < lo && c < 3'd7) return c + 3'd1;
    if (x > hi && c > 3'd0) return c - 3'd1;
    return c;
  endfunction

  function automatic int pixval(input int mode, input int color);
    int v;
    v = base[color] + int'($urandom_range(0, 23));
    if (v > 1023) v = 1023;
    case (mode)
      0:       return 512;
      1:       return (color == 0) ? 256 : 512;
      2:       return (color == 0) ? 1023 : (color == 1) ? 200 : 100;
      default: return v;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    arstn = 1'b0;
    repeat (n) tick();
    chk("rst_red",    o_red,    3'b100);
    chk("rst_green",  o_green,  3'b100);
    chk("rst_blue",   o_blue,   3'b100);
    chk("rst_locked", o_locked, 0);
    chk("rst_done",   o_done,   0);
    arstn  = 1'b1;
    primed = 1'b0;
    m_r    = 3'b100;
    m_b    = 3'b100;
  endtask

  // Frame boundary: the vs fall closes the frame in flight and opens a new one.
  task automatic boundary();
    logic [2:0] g;
    longint     gn, lo, hi;
    bit         lk;
    valid = 1'b0;
    vs    = 1'b1;
    g     = 3'($urandom_range(0, 7));
    green = g;
    tick();
    chk("green_gain", o_green, g);
    repeat (2) tick();
    vs = 1'b0;
    if (primed) begin
      if (!m_en) begin
        m_r = man_r;
        m_b = man_b;
        lk  = 1'b0;
      end else begin
        gn  = sum[1] / 2;
        lo  = gn - gn / 16;
        hi  = gn + gn / 16;
        lk  = (sum[0] >= lo && sum[0] <= hi) && (sum[2] >= lo && sum[2] <= hi);
        m_r = mstep(m_r, sum[0], lo, hi);
        m_b = mstep(m_b, sum[2], lo, hi);
      end
      sb.push_back('{cyc + 3, m_r, m_b, lk});
    end
    primed = 1'b1;
    for (int c = 0; c < 3; c++) sum[c] = 0;
    repeat (5) tick();
  endtask

  // Even lines carry G,R,G,R (pix3..pix0); odd lines B,G,B,G.
  task automatic send_line(input int mode, input int par);
    int col, v;
    for (int bt = 0; bt < BEATS; bt++) begin
      while ($urandom_range(0, 3) == 0) begin
        valid = 1'b0;
        tick();
      end
      for (int k = 0; k < 4; k++) begin
        if (par == 0) col = (k % 2 == 1) ? 1 : 0;
        else          col = (k % 2 == 1) ? 2 : 1;
        v = pixval(mode, col);
        data[k*P +: P] = P'(v);
        sum[col] += v;
      end
      valid = 1'b1;
      tick();
    end
    valid = 1'b0;
  endtask

  task automatic do_frame(input int mode);
    for (int c = 0; c < 3; c++) base[c] = int'($urandom_range(40, 1000));
    boundary();
    send_line(mode, 0);
    send_line(mode, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL frame_done: got unexpected pulse, expected none (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("red_code",   o_red,    e.r);
          chk("blue_code",  o_blue,   e.b);
          chk("locked",     o_locked, e.lk);
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t e;
    arstn = 1'b0; vs = 1'b0; valid = 1'b0; data = '0; en = 1'b1;
    man_r = 3'b000; man_b = 3'b000; green = 3'b100;
    m_en  = 1'b1;
    for (int c = 0; c < 3; c++) sum[c] = 0;
    do_reset(3);

    do_frame(0);
    do_frame(0);
    repeat (5) do_frame(1);
    repeat (9) do_frame(2);

    // Reset in the middle of an accumulating frame.
    boundary();
    send_line(2, 0);
    do_reset(2);
    send_line(2, 1);
    do_frame(3);

    en = 1'b0; man_r = 3'b010; man_b = 3'b110;
    tick();
    chk("man_red",    o_red,    3'b010);
    chk("man_blue",   o_blue,   3'b110);
    chk("man_locked", o_locked, 0);
    m_en = 1'b0; m_r = man_r; m_b = man_b;
    repeat (2) do_frame(1);
    en = 1'b1; m_en = 1'b1;
    repeat (2) do_frame(1);

    repeat (8) do_frame(3);
    boundary();

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL frame_done_missing: got none, expected pulse at cycle %0d", e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
